hazard_forwarding_unit: RTL and testbench
=========================================

# hazard_forwarding_unit

Pipeline hazard controller that produces the operand-forwarding select codes consumed by the execute-stage ALU input multiplexers, plus the fetch/decode stall and execute flush controls. It compares register specifiers across the decode, execute, memory and writeback stages, detects load-use hazards, and tracks a multi-cycle multiply/divide unit so that HI/LO reads wait for completion. It sits beside the pipeline registers and drives control only; it holds no datapath values.

## Interface
Parameters:
- MULT_CYCLES, 4, cycles multiply occupies HI/LO after issue (1..63)
- DIV_CYCLES, 32, cycles divide occupies HI/LO after issue (1..63)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- rs_decode, rt_decode  input  5 each  source specifiers in decode
- rs_execute, rt_execute  input  5 each  source specifiers in execute
- write_reg_execute, write_reg_memory, write_reg_writeback  input  5 each  destination per stage
- reg_write_execute, reg_write_memory, reg_write_writeback  input  1 each  GPR write enable per stage
- mem_to_reg_execute  input  1  execute-stage instruction is a load
- hi_lo_read_decode, hi_lo_read_execute  input  1 each  MFHI/MFLO in that stage
- hi_lo_write_memory, hi_lo_write_writeback  input  1 each  MTHI/MTLO in that stage
- mult_start_execute, div_start_execute  input  1 each  single-cycle issue pulse of MULT(U)/DIV(U)
- forward_one_execute  output  3  source A select
- forward_two_execute  output  3  source B select
- stall_fetch, stall_decode, flush_execute  output  1 each  pipeline control
- multdiv_busy  output  1  multiply/divide in progress

## Operation
- Forward codes: 000 register file, 001 result_writeback, 010 ALU_output_memory, 011 LO (one) / HI (two) writeback, 100 LO (one) / HI (two) memory; 101–111 never produced.
- GPR path (hi_lo_read_execute=0), evaluated independently for rs→one and rt→two: 010 if reg_write_memory and write_reg_memory≠0 and equal; else 001 if same test on writeback; else 000. Memory beats writeback.
- HI/LO path (hi_lo_read_execute=1): both outputs 100 if hi_lo_write_memory; else 011 if hi_lo_write_writeback; else 000. GPR matching ignored.
- Load-use stall: mem_to_reg_execute & reg_write_execute & write_reg_execute≠0 & (write_reg_execute==rs_decode | ==rt_decode).
- HI/LO stall: hi_lo_read_decode & (multdiv_busy | mult_start_execute | div_start_execute).
- stall_fetch = stall_decode = flush_execute = load-use stall | HI/LO stall.
- Busy counter (6 bits): on clock edge with div_start_execute loads DIV_CYCLES; else with mult_start_execute loads MULT_CYCLES; else decrements if nonzero. multdiv_busy = counter≠0.
- Start while busy reloads the counter (new op supersedes). Simultaneous mult and div start: divide wins.

## Timing
- All outputs combinational from inputs and counter state; zero-cycle latency.
- Issue pulse in cycle T → multdiv_busy high cycles T+1 … T+N (N = MULT_CYCLES/DIV_CYCLES), low at T+N+1.
- MFHI/MFLO in decode at T+N stalls; at T+N+1 proceeds.
- Reset asserted (any time, including mid-count): counter cleared immediately; multdiv_busy 0; while reset high all outputs forced 0 (forward codes 000, no stall/flush).
- First edge after reset release behaves as idle (counter 0).

## Configuration
- MULTDIV_BUSY_EN defined: busy counter, MULT_CYCLES/DIV_CYCLES and HI/LO stall as described.
- Undefined: counter not built, multdiv_busy tied 0, HI/LO stall term is 0 (multiply/divide treated as single-cycle); parameters accepted but unused. Forwarding and load-use logic unchanged.

## Test plan
- reg_write_memory=1, write_reg_memory=8, reg_write_writeback=1, write_reg_writeback=8, rs_execute=8, rt_execute=9 -> forward_one=010, forward_two=000.
- write_reg_memory=0 with reg_write_memory=1, rs_execute=0, writeback writes reg 0 -> forward_one=000 (register 0 never forwarded).
- Load in execute writing reg 5, rt_decode=5 -> stall_fetch=stall_decode=flush_execute=1 one cycle; next cycle with load in memory, forward_two=010.
- hi_lo_read_execute=1, hi_lo_write_memory=1, hi_lo_write_writeback=1 -> both forwards 100; drop memory write -> both 011.
- div_start_execute pulse at T, DIV_CYCLES=32, MFLO held in decode -> stall T..T+32, released T+33; reset asserted at T+10 -> busy and stall 0 immediately, remain 0 after release.
- MULT at T then DIV at T+2 (MULT_CYCLES=4) -> busy through T+34; without MULTDIV_BUSY_EN, multdiv_busy stays 0 and no stall.

Source files
------------

// File: rtl/hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forwarding_unit
// Brief    : Pipeline forwarding selects, load-use / HI-LO stall and flush,
//            with optional multiply/divide busy tracking (MULTDIV_BUSY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forwarding_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_decode,
  input  logic [4:0] rt_decode,
  input  logic [4:0] rs_execute,
  input  logic [4:0] rt_execute,
  input  logic [4:0] write_reg_execute,
  input  logic [4:0] write_reg_memory,
  input  logic [4:0] write_reg_writeback,
  input  logic       reg_write_execute,
  input  logic       reg_write_memory,
  input  logic       reg_write_writeback,
  input  logic       mem_to_reg_execute,
  input  logic       hi_lo_read_decode,
  input  logic       hi_lo_read_execute,
  input  logic       hi_lo_write_memory,
  input  logic       hi_lo_write_writeback,
  input  logic       mult_start_execute,
  input  logic       div_start_execute,
  output logic [2:0] forward_one_execute,
  output logic [2:0] forward_two_execute,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       flush_execute,
  output logic       multdiv_busy
);

  localparam logic [2:0] c_fwd_regfile  = 3'b000;
  localparam logic [2:0] c_fwd_wb       = 3'b001;
  localparam logic [2:0] c_fwd_mem      = 3'b010;
  localparam logic [2:0] c_fwd_hilo_wb  = 3'b011;
  localparam logic [2:0] c_fwd_hilo_mem = 3'b100;

  logic       w_mem_valid;
  logic       w_wb_valid;
  logic       w_rs_mem_hit;
  logic       w_rs_wb_hit;
  logic       w_rt_mem_hit;
  logic       w_rt_wb_hit;
  logic [2:0] w_fwd_one;
  logic [2:0] w_fwd_two;
  logic       w_load_use_stall;
  logic       w_hilo_stall;
  logic       w_busy;
  logic       w_stall;

  // Register 0 is hard-wired zero, so a write to it must never be forwarded.
  assign w_mem_valid  = reg_write_memory    && (write_reg_memory    != 5'd0);
  assign w_wb_valid   = reg_write_writeback && (write_reg_writeback != 5'd0);
  assign w_rs_mem_hit = w_mem_valid && (write_reg_memory    == rs_execute);
  assign w_rs_wb_hit  = w_wb_valid  && (write_reg_writeback == rs_execute);
  assign w_rt_mem_hit = w_mem_valid && (write_reg_memory    == rt_execute);
  assign w_rt_wb_hit  = w_wb_valid  && (write_reg_writeback == rt_execute);

  always_comb begin
    w_fwd_one = c_fwd_regfile;
    w_fwd_two = c_fwd_regfile;
    if (hi_lo_read_execute) begin
      if (hi_lo_write_memory) begin
        w_fwd_one = c_fwd_hilo_mem;
        w_fwd_two = c_fwd_hilo_mem;
      end else if (hi_lo_write_writeback) begin
        w_fwd_one = c_fwd_hilo_wb;
        w_fwd_two = c_fwd_hilo_wb;
      end
    end else begin
      // The younger producer in memory holds the newer value.
      if (w_rs_mem_hit)     w_fwd_one = c_fwd_mem;
      else if (w_rs_wb_hit) w_fwd_one = c_fwd_wb;
      if (w_rt_mem_hit)     w_fwd_two = c_fwd_mem;
      else if (w_rt_wb_hit) w_fwd_two = c_fwd_wb;
    end
  end

  assign w_load_use_stall = mem_to_reg_execute && reg_write_execute &&
                            (write_reg_execute != 5'd0) &&
                            ((write_reg_execute == rs_decode) ||
                             (write_reg_execute == rt_decode));

`ifdef MULTDIV_BUSY_EN
  localparam logic [5:0] c_mult_load = 6'(MULT_CYCLES);
  localparam logic [5:0] c_div_load  = 6'(DIV_CYCLES);

  logic [5:0] r_busy_count;

  // A new issue always reloads, so a later operation supersedes an earlier one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy_count <= 6'd0;
    end else if (div_start_execute) begin
      r_busy_count <= c_div_load;
    end else if (mult_start_execute) begin
      r_busy_count <= c_mult_load;
    end else if (r_busy_count != 6'd0) begin
      r_busy_count <= r_busy_count - 6'd1;
    end
  end

  assign w_busy       = (r_busy_count != 6'd0);
  assign w_hilo_stall = hi_lo_read_decode &&
                        (w_busy || mult_start_execute || div_start_execute);
`else
  logic w_unused_multdiv;

  assign w_busy           = 1'b0;
  assign w_hilo_stall     = 1'b0;
  assign w_unused_multdiv = ^{clk, hi_lo_read_decode, mult_start_execute,
                              div_start_execute, MULT_CYCLES, DIV_CYCLES};
`endif

  assign w_stall = w_load_use_stall || w_hilo_stall;

  // While reset is high every control output is held inactive.
  assign forward_one_execute = reset ? c_fwd_regfile : w_fwd_one;
  assign forward_two_execute = reset ? c_fwd_regfile : w_fwd_two;
  assign stall_fetch         = ~reset & w_stall;
  assign stall_decode        = ~reset & w_stall;
  assign flush_execute       = ~reset & w_stall;
  assign multdiv_busy        = ~reset & w_busy;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forwarding_unit
// Brief    : Directed self-checking bench for hazard_forwarding_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forwarding_unit;

`ifdef MULTDIV_BUSY_EN
  localparam bit c_en = 1'b1;
`else
  localparam bit c_en = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [4:0] rs_decode, rt_decode, rs_execute, rt_execute;
  logic [4:0] write_reg_execute, write_reg_memory, write_reg_writeback;
  logic       reg_write_execute, reg_write_memory, reg_write_writeback;
  logic       mem_to_reg_execute;
  logic       hi_lo_read_decode, hi_lo_read_execute;
  logic       hi_lo_write_memory, hi_lo_write_writeback;
  logic       mult_start_execute, div_start_execute;
  logic [2:0] forward_one_execute, forward_two_execute;
  logic       stall_fetch, stall_decode, flush_execute, multdiv_busy;

  int checks = 0;
  int errors = 0;

  hazard_forwarding_unit #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .rs_decode(rs_decode), .rt_decode(rt_decode),
    .rs_execute(rs_execute), .rt_execute(rt_execute),
    .write_reg_execute(write_reg_execute), .write_reg_memory(write_reg_memory),
    .write_reg_writeback(write_reg_writeback),
    .reg_write_execute(reg_write_execute), .reg_write_memory(reg_write_memory),
    .reg_write_writeback(reg_write_writeback),
    .mem_to_reg_execute(mem_to_reg_execute),
    .hi_lo_read_decode(hi_lo_read_decode), .hi_lo_read_execute(hi_lo_read_execute),
    .hi_lo_write_memory(hi_lo_write_memory), .hi_lo_write_writeback(hi_lo_write_writeback),
    .mult_start_execute(mult_start_execute), .div_start_execute(div_start_execute),
    .forward_one_execute(forward_one_execute), .forward_two_execute(forward_two_execute),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_execute(flush_execute), .multdiv_busy(multdiv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    rs_decode = 0; rt_decode = 0; rs_execute = 0; rt_execute = 0;
    write_reg_execute = 0; write_reg_memory = 0; write_reg_writeback = 0;
    reg_write_execute = 0; reg_write_memory = 0; reg_write_writeback = 0;
    mem_to_reg_execute = 0; hi_lo_read_decode = 0; hi_lo_read_execute = 0;
    hi_lo_write_memory = 0; hi_lo_write_writeback = 0;
    mult_start_execute = 0; div_start_execute = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    reg_write_memory = 1; write_reg_memory = 5'd3; rs_execute = 5'd3; rt_execute = 5'd3;
    mem_to_reg_execute = 1; reg_write_execute = 1; write_reg_execute = 5'd4; rs_decode = 5'd4;
    next_cycle(); next_cycle();
    checks++; if (forward_one_execute !== 3'b000) begin errors++; $display("FAIL reset_fwd1 got %b exp 000", forward_one_execute); end
    checks++; if (forward_two_execute !== 3'b000) begin errors++; $display("FAIL reset_fwd2 got %b exp 000", forward_two_execute); end
    checks++; if ({stall_fetch, stall_decode, flush_execute} !== 3'b000) begin errors++; $display("FAIL reset_stall got %b exp 000", {stall_fetch, stall_decode, flush_execute}); end
    checks++; if (multdiv_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", multdiv_busy); end
    clear_inputs();
    reset = 1'b0;
    next_cycle();
    checks++; if (multdiv_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", multdiv_busy); end
  endtask

  task automatic test_gpr_forward();
    clear_inputs();
    reg_write_memory = 1; write_reg_memory = 5'd8;
    reg_write_writeback = 1; write_reg_writeback = 5'd8;
    rs_execute = 5'd8; rt_execute = 5'd9;
    #1;
    checks++; if (forward_one_execute !== 3'b010) begin errors++; $display("FAIL gpr_mem_prio_fwd1 got %b exp 010", forward_one_execute); end
    checks++; if (forward_two_execute !== 3'b000) begin errors++; $display("FAIL gpr_nomatch_fwd2 got %b exp 000", forward_two_execute); end
    reg_write_memory = 0;
    #1;
    checks++; if (forward_one_execute !== 3'b001) begin errors++; $display("FAIL gpr_wb_fwd1 got %b exp 001", forward_one_execute); end
    reg_write_memory = 1; write_reg_memory = 5'd9; write_reg_writeback = 5'd8;
    #1;
    checks++; if (forward_one_execute !== 3'b001) begin errors++; $display("FAIL gpr_split_fwd1 got %b exp 001", forward_one_execute); end
    checks++; if (forward_two_execute !== 3'b010) begin errors++; $display("FAIL gpr_split_fwd2 got %b exp 010", forward_two_execute); end
    reg_write_memory = 0; write_reg_writeback = 5'd9;
    #1;
    checks++; if (forward_two_execute !== 3'b001) begin errors++; $display("FAIL gpr_wb_fwd2 got %b exp 001", forward_two_execute); end
    checks++; if (forward_one_execute !== 3'b000) begin errors++; $display("FAIL gpr_wb_fwd1_none got %b exp 000", forward_one_execute); end
  endtask

  task automatic test_reg_zero();
    clear_inputs();
    reg_write_memory = 1; write_reg_memory = 5'd0;
    reg_write_writeback = 1; write_reg_writeback = 5'd0;
    rs_execute = 5'd0; rt_execute = 5'd0;
    #1;
    checks++; if (forward_one_execute !== 3'b000) begin errors++; $display("FAIL zero_fwd1 got %b exp 000", forward_one_execute); end
    checks++; if (forward_two_execute !== 3'b000) begin errors++; $display("FAIL zero_fwd2 got %b exp 000", forward_two_execute); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    next_cycle();
    mem_to_reg_execute = 1; reg_write_execute = 1; write_reg_execute = 5'd5; rt_decode = 5'd5;
    #1;
    checks++; if ({stall_fetch, stall_decode, flush_execute} !== 3'b111) begin errors++; $display("FAIL load_use_rt got %b exp 111", {stall_fetch, stall_decode, flush_execute}); end
    rt_decode = 5'd6; rs_decode = 5'd5;
    #1;
    checks++; if ({stall_fetch, stall_decode, flush_execute} !== 3'b111) begin errors++; $display("FAIL load_use_rs got %b exp 111", {stall_fetch, stall_decode, flush_execute}); end
    mem_to_reg_execute = 0;
    #1;
    checks++; if (stall_decode !== 1'b0) begin errors++; $display("FAIL load_use_not_load got %b exp 0", stall_decode); end
    mem_to_reg_execute = 1; reg_write_execute = 0;
    #1;
    checks++; if (stall_fetch !== 1'b0) begin errors++; $display("FAIL load_use_no_write got %b exp 0", stall_fetch); end
    reg_write_execute = 1; write_reg_execute = 5'd0; rs_decode = 5'd0;
    #1;
    checks++; if (flush_execute !== 1'b0) begin errors++; $display("FAIL load_use_reg0 got %b exp 0", flush_execute); end
    // Load advances to memory; dependent instruction now in execute.
    next_cycle();
    clear_inputs();
    reg_write_memory = 1; write_reg_memory = 5'd5; rt_execute = 5'd5;
    #1;
    checks++; if (forward_two_execute !== 3'b010) begin errors++; $display("FAIL load_use_fwd2 got %b exp 010", forward_two_execute); end
    checks++; if (stall_decode !== 1'b0) begin errors++; $display("FAIL load_use_released got %b exp 0", stall_decode); end
  endtask

  task automatic test_hilo_forward();
    clear_inputs();
    hi_lo_read_execute = 1; hi_lo_write_memory = 1; hi_lo_write_writeback = 1;
    reg_write_memory = 1; write_reg_memory = 5'd7; rs_execute = 5'd7; rt_execute = 5'd7;
    #1;
    checks++; if (forward_one_execute !== 3'b100) begin errors++; $display("FAIL hilo_mem_fwd1 got %b exp 100", forward_one_execute); end
    checks++; if (forward_two_execute !== 3'b100) begin errors++; $display("FAIL hilo_mem_fwd2 got %b exp 100", forward_two_execute); end
    hi_lo_write_memory = 0;
    #1;
    checks++; if (forward_one_execute !== 3'b011) begin errors++; $display("FAIL hilo_wb_fwd1 got %b exp 011", forward_one_execute); end
    checks++; if (forward_two_execute !== 3'b011) begin errors++; $display("FAIL hilo_wb_fwd2 got %b exp 011", forward_two_execute); end
    hi_lo_write_writeback = 0;
    #1;
    checks++; if ({forward_one_execute, forward_two_execute} !== 6'b000000) begin errors++; $display("FAIL hilo_none got %b exp 000000", {forward_one_execute, forward_two_execute}); end
  endtask

  task automatic test_div_stall();
    clear_inputs();
    next_cycle();
    hi_lo_read_decode = 1; div_start_execute = 1;
    #1;
    checks++; if (stall_decode !== c_en) begin errors++; $display("FAIL div_stall_T got %b exp %b", stall_decode, c_en); end
    for (int k = 1; k <= 33; k++) begin
      next_cycle();
      div_start_execute = 0;
      #1;
      checks++; if (multdiv_busy !== (c_en && k <= 32)) begin errors++; $display("FAIL div_busy_T+%0d got %b exp %b", k, multdiv_busy, c_en && k <= 32); end
      checks++; if (stall_fetch !== (c_en && k <= 32)) begin errors++; $display("FAIL div_stall_T+%0d got %b exp %b", k, stall_fetch, c_en && k <= 32); end
    end
  endtask

  task automatic test_reset_mid_count();
    clear_inputs();
    next_cycle();
    hi_lo_read_decode = 1; div_start_execute = 1;
    next_cycle();
    div_start_execute = 0;
    for (int k = 2; k <= 10; k++) next_cycle();
    #1;
    checks++; if (multdiv_busy !== c_en) begin errors++; $display("FAIL midcount_busy_before got %b exp %b", multdiv_busy, c_en); end
    reset = 1'b1;
    #1;
    checks++; if (multdiv_busy !== 1'b0) begin errors++; $display("FAIL midcount_busy_in_reset got %b exp 0", multdiv_busy); end
    checks++; if (stall_decode !== 1'b0) begin errors++; $display("FAIL midcount_stall_in_reset got %b exp 0", stall_decode); end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++; if ({multdiv_busy, stall_decode} !== 2'b00) begin errors++; $display("FAIL midcount_after_release got %b exp 00", {multdiv_busy, stall_decode}); end
    next_cycle();
    checks++; if ({multdiv_busy, stall_decode} !== 2'b00) begin errors++; $display("FAIL midcount_later got %b exp 00", {multdiv_busy, stall_decode}); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    next_cycle();
    mult_start_execute = 1;
    next_cycle();
    mult_start_execute = 0;
    #1;
    checks++; if (multdiv_busy !== c_en) begin errors++; $display("FAIL b2b_busy_T+1 got %b exp %b", multdiv_busy, c_en); end
    next_cycle();
    div_start_execute = 1;
    for (int k = 3; k <= 35; k++) begin
      next_cycle();
      div_start_execute = 0;
      #1;
      checks++; if (multdiv_busy !== (c_en && k <= 34)) begin errors++; $display("FAIL b2b_busy_T+%0d got %b exp %b", k, multdiv_busy, c_en && k <= 34); end
    end
    checks++; if (stall_fetch !== 1'b0) begin errors++; $display("FAIL b2b_no_hilo_read_stall got %b exp 0", stall_fetch); end
  endtask

  task automatic test_simultaneous_start();
    clear_inputs();
    next_cycle();
    mult_start_execute = 1; div_start_execute = 1;
    for (int k = 1; k <= 33; k++) begin
      next_cycle();
      mult_start_execute = 0; div_start_execute = 0;
      #1;
      if (k == 5 || k == 32 || k == 33) begin
        checks++; if (multdiv_busy !== (c_en && k <= 32)) begin errors++; $display("FAIL simul_busy_T+%0d got %b exp %b", k, multdiv_busy, c_en && k <= 32); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_gpr_forward();
    test_reg_zero();
    test_load_use();
    test_hilo_forward();
    test_div_stall();
    test_reset_mid_count();
    test_back_to_back();
    test_simultaneous_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
